// File: rtl/line_buffer_pp.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_pp
// Description : Ping-pong RGB line buffer. The pixel source fills one bank
//               while scan-out drains the other, and the banks swap
//               automatically at line boundaries. Supports short lines
//               (WrEol), back-pressure (WrReady) and overflow reporting.
// Ports       : Clock      - rising-edge clock for all state
//               ResetN     - asynchronous active-low reset
//               WrValid    - write pixel offered
//               WrData     - pixel to store (channel 0 in the MS slice)
//               WrEol      - this pixel ends the line
//               WrReady    - write bank can accept a pixel
//               WrOverflow - one-cycle pulse after a dropped write
//               RdReq      - request next pixel from read bank
//               RdValid    - RdData/RdLast valid this cycle
//               RdData     - registered pixel out
//               RdLast     - last pixel of the line
//               LinesAvail - number of full banks (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_pp #(
    parameter int CH_W     = 8,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 128,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                     Clock,
    input  logic                     ResetN,
    input  logic                     WrValid,
    input  logic [CHANNELS*CH_W-1:0] WrData,
    input  logic                     WrEol,
    output logic                     WrReady,
    output logic                     WrOverflow,
    input  logic                     RdReq,
    output logic                     RdValid,
    output logic [CHANNELS*CH_W-1:0] RdData,
    output logic                     RdLast,
    output logic [1:0]               LinesAvail
);

    localparam int             c_PW        = CHANNELS * CH_W;
    localparam logic [AW-1:0]  c_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0]  c_ADDR_ONE  = AW'(1);
    localparam logic [AW:0]    c_LEN_ONE   = (AW + 1)'(1);

    // Pixel storage, two banks; contents are deliberately not reset.
    logic [c_PW-1:0] r_mem [0:1][0:DEPTH-1];

    logic [1:0]      r_full;
    logic [AW:0]     r_len [0:1];
    logic            r_wb;
    logic            r_rb;
    logic [AW-1:0]   r_waddr;
    logic [AW-1:0]   r_raddr;

    logic            r_rd_valid;
    logic            r_rd_last;
    logic [c_PW-1:0] r_rd_data;
    logic            r_wr_ovf;
    logic [1:0]      r_lines;

    logic            w_wr_acc;
    logic            w_wr_end;
    logic            w_rd_acc;
    logic            w_rd_end;
    logic [1:0]      w_full_nxt;

    assign WrReady    = !r_full[r_wb];
    assign WrOverflow = r_wr_ovf;
    assign RdValid    = r_rd_valid;
    assign RdData     = r_rd_data;
    assign RdLast     = r_rd_last;
    assign LinesAvail = r_lines;

    assign w_wr_acc = WrValid && WrReady;
    assign w_wr_end = w_wr_acc && ((r_waddr == c_LAST_ADDR) || WrEol);
    assign w_rd_acc = RdReq && r_full[r_rb];
    assign w_rd_end = w_rd_acc && ({1'b0, r_raddr} == (r_len[r_rb] - c_LEN_ONE));

    // A write only targets an empty bank and a read only a full one, so the
    // set and clear below can never hit the same bank in one cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_end) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_rd_end) begin
            w_full_nxt[r_rb] = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_wr_acc) begin
            r_mem[r_wb][r_waddr] <= WrData;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_full     <= 2'b00;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_waddr    <= '0;
            r_raddr    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
            r_wr_ovf   <= 1'b0;
            r_lines    <= 2'd0;
        end else begin
            r_full     <= w_full_nxt;
            r_lines    <= {1'b0, w_full_nxt[0]} + {1'b0, w_full_nxt[1]};
            r_wr_ovf   <= WrValid && !WrReady;
            r_rd_valid <= w_rd_acc;
            r_rd_last  <= w_rd_end;

            if (w_wr_acc) begin
                if (w_wr_end) begin
                    r_len[r_wb] <= {1'b0, r_waddr} + c_LEN_ONE;
                    r_waddr     <= '0;
                    r_wb        <= ~r_wb;
                end else begin
                    r_waddr <= r_waddr + c_ADDR_ONE;
                end
            end

            // RdData holds its previous value when no read is accepted.
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rb][r_raddr];
                if (w_rd_end) begin
                    r_raddr <= '0;
                    r_rb    <= ~r_rb;
                end else begin
                    r_raddr <= r_raddr + c_ADDR_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/line_buffer_pp.md
# line_buffer_pp

Parametrised ping-pong RGB line buffer, the successor to the single-bank 128-entry pixel buffer in the display adaptor datapath. It holds two line banks. The pixel source fills one bank while the display scan-out side drains the other, and the banks swap automatically at line boundaries. Compared with the single-bank buffer it adds generic channel count and width, internal address sequencing, short-line support, back-pressure and overflow reporting.

## Interface
- CH_W, default 8: bits per colour channel.
- CHANNELS, default 3: channels per pixel; channel 0 sits in the MS slice (R,G,B order at default).
- DEPTH, default 128: max pixels per line (per bank); must be at least 2.
- AW, default $clog2(DEPTH): address/count width.

- Clock  in  1  rising-edge clock for all state.
- ResetN  in  1  asynchronous, active-low reset.
- WrValid  in  1  write pixel offered.
- WrData  in  CHANNELS*CH_W  pixel to store.
- WrEol  in  1  with WrValid: this pixel ends the line (short line).
- WrReady  out  1  write bank can accept; a write happens on WrValid&&WrReady.
- WrOverflow  out  1  one-cycle pulse: WrValid while !WrReady (pixel dropped).
- RdReq  in  1  request next pixel from read bank.
- RdValid  out  1  RdData/RdLast valid this cycle.
- RdData  out  CHANNELS*CH_W  registered pixel out.
- RdLast  out  1  with RdValid: last pixel of the line.
- LinesAvail  out  2  number of full banks (0..2).

## Operation
- Storage: two banks of DEPTH×(CHANNELS*CH_W). Per bank: full flag and length len[b] (AW+1 bits, 1..DEPTH).
- Write side: bank pointer wb and address waddr.
  - WrReady = !full[wb].
  - On an accepted write: mem[wb][waddr] <= WrData, then waddr++.
  - If waddr==DEPTH-1 or WrEol: full[wb]<=1, len[wb]<=waddr+1, waddr<=0, wb<=~wb.
- Read side: bank pointer rb and address raddr.
  - A read is accepted when RdReq && full[rb].
  - On an accepted read: RdData <= mem[rb][raddr], RdValid<=1, RdLast <= (raddr==len[rb]-1).
  - If that was the last pixel: full[rb]<=0, raddr<=0, rb<=~rb. Otherwise raddr++.
- RdReq while !full[rb] is ignored: RdValid=0, RdData holds its last value.
- Write and read never target the same bank, because writes need !full and reads need full.
- Simultaneous write-complete on one bank and read-complete on the other in the same cycle are both honoured.
- LinesAvail = full[0]+full[1], registered.
- Reset (asynchronous, any time, including mid-line):
  - wb=rb=0, waddr=raddr=0, full=0, len=0.
  - RdValid=0, RdLast=0, RdData=0, WrOverflow=0, LinesAvail=0.
  - WrReady=1 after release.
  - Memory contents are not reset; partially written or partially read lines are discarded.

## Timing
- Write to readable: full is set at the edge that accepts the last pixel. RdReq is honoured from the next cycle.
- Read latency: 1 cycle. RdReq accepted at edge N gives RdValid/RdData/RdLast valid after edge N, for one cycle.
- Read throughput: RdReq held high streams one pixel per cycle.
- Bank release: full[rb] clears at the edge that accepts the last read. If that bank is wb, WrReady rises in the next cycle.
- Write throughput: one pixel per cycle. There are no bubbles at a bank swap if the other bank is empty.
- Read side across banks: when both banks are full, reads stream across the swap with no bubble; RdLast marks each line end.
- WrOverflow: registered, asserted the cycle after a WrValid&&!WrReady edge. The dropped pixel does not advance waddr.
- WrEol on the first pixel: gives len=1, and RdLast is asserted with the first read.

## Test plan
- Reset, then 128 writes of RGB=(i,i+1,i+2), then 128 RdReq. Required: RdData sequence 0x000102… in order; RdLast only on pixel 127; LinesAvail goes 0→1→0.
- Write a 40-pixel line ending in WrEol, then read it. Required: RdLast on the 40th read; a 41st RdReq gives no RdValid.
- Fill both banks (256 writes), then write once more. Required: WrReady=0, WrOverflow pulses once, LinesAvail=2. Reading back gives both lines intact.
- Continuous streaming: write and read together at one pixel per cycle for 4 lines after 1 line of pre-fill. Required: no WrOverflow, no read bubbles, and a 1-cycle RdReq→RdValid latency throughout.
- Assert ResetN low mid-write at pixel 60 while reading bank 1 at pixel 30. Required: all outputs go to reset values immediately; after release WrReady=1, LinesAvail=0, and RdReq produces no RdValid.
- Set CHANNELS=4, CH_W=10, DEPTH=16. Required: a 16-pixel round trip of 40-bit data matches, and RdLast is on pixel 15.
